// File: rtl/conv_addr_seq_if.sv
// Handshake and address bus of the convolution address sequencer.
// The slave modport is the sequencer. The master modport is its controller or consumer.
interface conv_addr_seq_if #(
  parameter int ADDR_W = 8,
  parameter int NBANK  = 11,
  parameter int KSIZE  = 11
);
  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  logic                    go;
  logic                    stall;
  logic [NBANK*ADDR_W-1:0] addr;
  logic [KW-1:0]           filter_addr;
  logic [5:0]              row;
  logic                    tap_valid;
  logic                    first_tap;
  logic                    last_tap;
  logic                    win_done;
  logic                    busy;
  logic                    done;

  modport master (
    output go, stall,
    input  addr, filter_addr, row, tap_valid, first_tap, last_tap, win_done, busy, done
  );

  modport slave (
    input  go, stall,
    output addr, filter_addr, row, tap_valid, first_tap, last_tap, win_done, busy, done
  );
endinterface

// File: rtl/conv_addr_seq.sv
// Convolution address sequencer: per-bank read addresses, tap index and accumulator control.
// Optional feature macro: CONV_ADDR_SEQ_STALL_EN (when defined, stall freezes every register).
module conv_addr_seq #(
  parameter int ADDR_W    = 8,
  parameter int NBANK     = 11,
  parameter int KSIZE     = 11,
  parameter int STRIDE    = 4,
  parameter int OUT_COLS  = 7,
  parameter int NPASS     = 7,
  parameter int ROW_WORDS = 35,
  parameter int PIPE_LAT  = 4
) (
  input  logic            clk,
  input  logic            rst,
  conv_addr_seq_if.slave  bus
);
  localparam int KW = (KSIZE    > 1) ? $clog2(KSIZE)    : 1;
  localparam int CW = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;
  localparam int PW = (NPASS    > 1) ? $clog2(NPASS)    : 1;
  localparam int BW = (NBANK    > 1) ? $clog2(NBANK)    : 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t              state_q, state_d;
  logic [KW-1:0]       k_q;
  logic [CW-1:0]       c_q;
  logic [PW-1:0]       p_q;
  logic [5:0]          row_q;
  logic [ADDR_W-1:0]   col_off_q;   // c*STRIDE
  logic [ADDR_W-1:0]   base_div_q;  // (p*STRIDE) / NBANK
  logic [BW-1:0]       base_mod_q;  // (p*STRIDE) % NBANK
  logic [BW-1:0]       base_mod_nxt;
  logic                base_carry;
  logic [DW-1:0]       drain_q;
  logic [PIPE_LAT-1:0] wd_sr;
  logic                hold;

`ifdef CONV_ADDR_SEQ_STALL_EN
  assign hold = bus.stall;
`else
  logic unused_stall;
  assign unused_stall = bus.stall;
  assign hold         = 1'b0;
`endif

  logic k_wrap, c_wrap, p_last, seq_end, drain_end;
  assign k_wrap    = (k_q == KW'(KSIZE - 1));
  assign c_wrap    = (c_q == CW'(OUT_COLS - 1));
  assign p_last    = (p_q == PW'(NPASS - 1));
  assign seq_end   = (state_q == RUN) && k_wrap && c_wrap && p_last;
  assign drain_end = (drain_q == DW'(PIPE_LAT - 1));

  // Incremental pass base: the top row advances by STRIDE, which never exceeds NBANK.
  always_comb begin
    int mod_sum;
    mod_sum = int'(base_mod_q) + STRIDE;
    base_carry   = (mod_sum >= NBANK);
    base_mod_nxt = base_carry ? BW'(mod_sum - NBANK) : BW'(mod_sum);
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.go)   state_d = RUN;
      RUN:     if (seq_end)  state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      c_q        <= '0;
      p_q        <= '0;
      row_q      <= '0;
      col_off_q  <= '0;
      base_div_q <= '0;
      base_mod_q <= '0;
      drain_q    <= '0;
      // NOTE: the win_done delay line is reset too; after an abort a stale bit would report a window that never finished.
      wd_sr      <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      wd_sr   <= (wd_sr << 1) | PIPE_LAT'(bus.last_tap);
      case (state_q)
        IDLE: begin
          if (bus.go) begin
            k_q        <= '0;
            c_q        <= '0;
            p_q        <= '0;
            row_q      <= '0;
            col_off_q  <= '0;
            base_div_q <= '0;
            base_mod_q <= '0;
          end
        end
        RUN: begin
          drain_q <= '0;
          // At the final tap the counters stay put so the outputs hold during DRAIN/FIN.
          if (!seq_end) begin
            if (!k_wrap) begin
              k_q <= k_q + 1'b1;
            end else begin
              k_q <= '0;
              if (!c_wrap) begin
                c_q       <= c_q + 1'b1;
                col_off_q <= col_off_q + ADDR_W'(STRIDE);
              end else begin
                c_q        <= '0;
                col_off_q  <= '0;
                p_q        <= p_q + 1'b1;
                row_q      <= row_q + 6'(STRIDE);
                base_mod_q <= base_mod_nxt;
                base_div_q <= base_div_q + ADDR_W'(base_carry);
              end
            end
          end
        end
        DRAIN:   drain_q <= drain_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Bank b holds the window row congruent to b; banks below the base remainder
  // already hold the next stored row, one ROW_WORDS block further in.
  always_comb begin
    logic [ADDR_W-1:0] bank_div;
    bus.addr = '0;
    bank_div = '0;
    for (int b = 0; b < NBANK; b++) begin
      bank_div = base_div_q + ((BW'(b) < base_mod_q) ? ADDR_W'(1) : ADDR_W'(0));
      bus.addr[b*ADDR_W +: ADDR_W] = bank_div * ADDR_W'(ROW_WORDS) + col_off_q + ADDR_W'(k_q);
    end
  end

  assign bus.filter_addr = k_q;
  assign bus.row         = row_q;
  assign bus.tap_valid   = (state_q == RUN);
  assign bus.first_tap   = (state_q == RUN) && (k_q == '0);
  assign bus.last_tap    = (state_q == RUN) && k_wrap;
  assign bus.win_done    = wd_sr[PIPE_LAT-1];
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == FIN);
endmodule

// File: tb/tb_conv_addr_seq.sv
// Self-checking bench for conv_addr_seq against a tap-index reference model.
// Each observed cycle is mapped to a model state index that advances only on unstalled cycles.
module tb_conv_addr_seq;
  localparam int ADDR_W    = 8;
  localparam int NBANK     = 11;
  localparam int KSIZE     = 11;
  localparam int STRIDE    = 4;
  localparam int OUT_COLS  = 7;
  localparam int NPASS     = 7;
  localparam int ROW_WORDS = 35;
  localparam int PIPE_LAT  = 4;
  localparam int KW        = $clog2(KSIZE);
  localparam int AW        = NBANK * ADDR_W;
  localparam int NTAP      = NPASS * OUT_COLS * KSIZE;
  localparam int DONE_A    = NTAP + PIPE_LAT;
`ifdef CONV_ADDR_SEQ_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_addr_seq_if #(.ADDR_W(ADDR_W), .NBANK(NBANK), .KSIZE(KSIZE)) bus ();

  conv_addr_seq #(
    .ADDR_W(ADDR_W), .NBANK(NBANK), .KSIZE(KSIZE), .STRIDE(STRIDE),
    .OUT_COLS(OUT_COLS), .NPASS(NPASS), .ROW_WORDS(ROW_WORDS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: walk the window rows, place each row in its bank, address it by plain arithmetic.
  function automatic logic [AW-1:0] model_addr(input int t);
    int p, c, k;
    logic [AW-1:0] v;
    v = '0;
    p = t / (OUT_COLS * KSIZE);
    c = (t / KSIZE) % OUT_COLS;
    k = t % KSIZE;
    for (int r = p * STRIDE; r < p * STRIDE + NBANK; r++)
      v[(r % NBANK) * ADDR_W +: ADDR_W] = ADDR_W'((r / NBANK) * ROW_WORDS + c * STRIDE + k);
    return v;
  endfunction

  function automatic logic [AW+KW+6+6-1:0] all_outputs();
    return {bus.addr, bus.filter_addr, bus.row, bus.tap_valid, bus.first_tap,
            bus.last_tap, bus.win_done, bus.busy, bus.done};
  endfunction

  // Launch one sequence and compare every cycle until it returns to IDLE.
  task automatic run_seq(input string name, input int launch, input bit hold_go,
                         input int stall_tap, input int stall_len, input int stall_last,
                         input int pct, input int abort_tap,
                         output int n_tap, output int n_wd, output int n_done,
                         output int done_raw, output int n_stall);
    int a, raw, dwell, t;
    bit stl, eff, ev;
    logic [5:0] exp_ctl, got_ctl;
    n_tap = 0; n_wd = 0; n_done = 0; done_raw = -1; n_stall = 0;
    bus.go = 1'b0; bus.stall = 1'b0;
    repeat (launch) tick();
    bus.go = 1'b1;
    tick();
    if (!hold_go) bus.go = 1'b0;
    a = 0; raw = 0; dwell = 0;
    while (1) begin
      if (raw > 3000) begin
        checks++; errors++;
        $display("FAIL %s timeout: state index %0d after %0d cycles, required completion", name, a, raw);
        break;
      end
      if (hold_go && a == DONE_A + 2) begin
        checks++;
        if ({bus.tap_valid, bus.first_tap, bus.filter_addr} !== {2'b11, KW'(0)} || bus.addr !== model_addr(0)) begin
          errors++;
          $display("FAIL %s restart: valid=%b first=%b k=%0d addr=%h, required 1 1 0 %h",
                   name, bus.tap_valid, bus.first_tap, bus.filter_addr, bus.addr, model_addr(0));
        end
        break;
      end
      ev = (a < NTAP);
      t  = ev ? a : NTAP - 1;
      exp_ctl = {ev, ev && (t % KSIZE == 0), ev && (t % KSIZE == KSIZE - 1),
                 (a >= PIPE_LAT) && (a - PIPE_LAT < NTAP) && ((a - PIPE_LAT) % KSIZE == KSIZE - 1),
                 a <= DONE_A, a == DONE_A};
      got_ctl = {bus.tap_valid, bus.first_tap, bus.last_tap, bus.win_done, bus.busy, bus.done};
      checks++;
      if (got_ctl !== exp_ctl) begin
        errors++;
        $display("FAIL %s ctl idx=%0d: got %b, required %b (valid first last wdone busy done)", name, a, got_ctl, exp_ctl);
      end
      checks++;
      if (bus.addr !== model_addr(t)) begin
        errors++;
        $display("FAIL %s addr idx=%0d: got %h, required %h", name, a, bus.addr, model_addr(t));
      end
      checks++;
      if (bus.filter_addr !== KW'(t % KSIZE) || bus.row !== 6'((t / (OUT_COLS * KSIZE)) * STRIDE)) begin
        errors++;
        $display("FAIL %s k/row idx=%0d: got %0d/%0d, required %0d/%0d", name, a, bus.filter_addr, bus.row,
                 t % KSIZE, (t / (OUT_COLS * KSIZE)) * STRIDE);
      end
      if (a == DONE_A + 1 && !hold_go) break;
      if (a == abort_tap) begin
        rst = 1'b1; bus.stall = 1'b1; bus.go = 1'b0;
        tick();
        checks++;
        if (all_outputs() !== '0) begin
          errors++;
          $display("FAIL %s abort_zero: got %h, required all zero", name, all_outputs());
        end
        rst = 1'b0; bus.stall = 1'b0;
        repeat (PIPE_LAT + 3) begin
          tick();
          checks++;
          if ({bus.tap_valid, bus.win_done, bus.busy, bus.done} !== 4'b0) begin
            errors++;
            $display("FAIL %s abort_quiet: valid/wdone/busy/done=%b, required 0000", name,
                     {bus.tap_valid, bus.win_done, bus.busy, bus.done});
          end
        end
        return;
      end
      stl = (a == stall_tap && dwell < stall_len) || (a == NTAP - 1 && dwell < stall_last) ||
            (a < DONE_A && int'($urandom_range(0, 99)) < pct);
      eff = STALL_EN && stl;
      if (!eff) begin
        n_tap += int'(bus.tap_valid);
        n_wd  += int'(bus.win_done);
        if (bus.done) begin
          n_done++;
          done_raw = raw;
        end
      end
      bus.stall = stl;
      tick();
      raw++;
      if (eff) begin
        n_stall++;
        dwell++;
      end else begin
        a++;
        dwell = 0;
      end
    end
    bus.stall = 1'b0;
    bus.go = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.go = 1'b1; bus.stall = 1'b1;
    repeat (3) tick();
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h, required all zero", all_outputs());
    end
    rst = 1'b0; bus.go = 1'b0; bus.stall = 1'b0;
    repeat (2) tick();
    checks++;
    if (all_outputs() !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h, required all zero", all_outputs());
    end
  endtask

  task automatic test_full_sequence(input string name);
    int n_tap, n_wd, n_done, done_raw, n_stall;
    run_seq(name, int'($urandom_range(0, 5)), 1'b0, -1, 0, 0, 0, -1, n_tap, n_wd, n_done, done_raw, n_stall);
    checks++;
    if (n_tap != 539 || n_wd != 49 || n_done != 1 || done_raw != 543) begin
      errors++;
      $display("FAIL %s totals: taps=%0d wdone=%0d done=%0d at %0d, required 539 49 1 at 543",
               name, n_tap, n_wd, n_done, done_raw);
    end
  endtask

  task automatic test_address_points();
    int e, n;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int a = 0; a < NTAP; a++) begin
      if (a == 0 || a == 77 || a == 538) begin
        for (int b = 0; b < NBANK; b++) begin
          e = (a == 0) ? 0 : (a == 77) ? ((b < 4) ? 35 : 0) : ((b < 2) ? 139 : 104);
          checks++;
          if (bus.addr[b*ADDR_W +: ADDR_W] !== ADDR_W'(e)) begin
            errors++;
            $display("FAIL addr_point tap=%0d bank=%0d: got %0d, required %0d", a, b, bus.addr[b*ADDR_W +: ADDR_W], e);
          end
        end
      end
      tick();
    end
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL addr_point_end: busy=%b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  task automatic test_stall();
    int n_tap, n_wd, n_done, done_raw, n_stall;
    run_seq("stall", 1, 1'b0, 20, 3, 1, 0, -1, n_tap, n_wd, n_done, done_raw, n_stall);
    checks++;
    if (n_tap != 539 || n_wd != 49 || n_done != 1 || done_raw != 543 + (STALL_EN ? 4 : 0)) begin
      errors++;
      $display("FAIL stall totals: taps=%0d wdone=%0d done=%0d at %0d, required 539 49 1 at %0d",
               n_tap, n_wd, n_done, done_raw, 543 + (STALL_EN ? 4 : 0));
    end
  endtask

  task automatic test_random_stall();
    int n_tap, n_wd, n_done, done_raw, n_stall;
    run_seq("rand_stall", 2, 1'b0, -1, 0, 0, 15, -1, n_tap, n_wd, n_done, done_raw, n_stall);
    checks++;
    if (n_tap != 539 || n_wd != 49 || n_done != 1 || done_raw != 543 + n_stall) begin
      errors++;
      $display("FAIL rand_stall totals: taps=%0d wdone=%0d done=%0d at %0d, required 539 49 1 at %0d",
               n_tap, n_wd, n_done, done_raw, 543 + n_stall);
    end
  endtask

  task automatic test_abort();
    int n_tap, n_wd, n_done, done_raw, n_stall;
    run_seq("abort", 0, 1'b0, -1, 0, 0, 0, 100, n_tap, n_wd, n_done, done_raw, n_stall);
    checks++;
    if (n_done != 0 || n_tap != 100) begin
      errors++;
      $display("FAIL abort counts: taps=%0d done=%0d, required 100 0", n_tap, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_tap, n_wd, n_done, done_raw, n_stall;
    run_seq("back_to_back", 0, 1'b1, -1, 0, 0, 0, -1, n_tap, n_wd, n_done, done_raw, n_stall);
    checks++;
    if (n_tap != 539 || n_done != 1 || done_raw != 543) begin
      errors++;
      $display("FAIL back_to_back totals: taps=%0d done=%0d at %0d, required 539 1 at 543", n_tap, n_done, done_raw);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.go = 1'b0;
    bus.stall = 1'b0;
    test_reset();
    test_full_sequence("full");
    test_address_points();
    test_stall();
    test_random_stall();
    test_abort();
    test_full_sequence("restart");
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
